// File: rtl/lsu_mem_if.sv
// Load/store unit between the execute stage and a fixed-latency data memory port.
// Handles request/response handshake, byte-lane steering, load extension and fault detection.
module lsu_mem_if #(
    parameter int XLEN    = 32,
    parameter int MEM_LAT = 1,
    parameter int NB      = XLEN / 8,
    parameter int OFFW    = $clog2(NB)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              resp_valid,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_fault,
    output logic              data_read,
    output logic [XLEN-1:0]   data_addr,
    output logic [NB-1:0]     data_write,
    output logic [XLEN-1:0]   data_in,
    input  logic [XLEN-1:0]   data_out
);

    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    function automatic logic f3_illegal(input logic [2:0] f3, input logic we);
        logic bad;
        case (f3)
            3'b000, 3'b001, 3'b010: bad = 1'b0;
            3'b011:                 bad = (XLEN != 64);
            3'b100, 3'b101:         bad = we;
            3'b110:                 bad = we || (XLEN != 64);
            default:                bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [2:0] off3);
        logic m;
        case (size)
            2'd0:    m = 1'b0;
            2'd1:    m = off3[0];
            2'd2:    m = |off3[1:0];
            default: m = |off3;
        endcase
        return m;
    endfunction

    function automatic logic [NB-1:0] lane_mask(input logic [1:0] size, input logic [OFFW-1:0] off);
        logic [7:0] base;
        case (size)
            2'd0:    base = 8'h01;
            2'd1:    base = 8'h03;
            2'd2:    base = 8'h0F;
            default: base = 8'hFF;
        endcase
        return NB'(base) << off;
    endfunction

    // Extension is done at 64 bits and truncated, so W on XLEN=32 passes through unchanged.
    function automatic logic [XLEN-1:0] load_extend(input logic [XLEN-1:0] dout,
                                                     input logic [2:0]      f3,
                                                     input logic [OFFW-1:0] off);
        logic [XLEN-1:0] sh;
        logic [63:0]     w;
        logic            sx;
        sh = dout >> {off, 3'b000};
        sx = ~f3[2];
        case (f3[1:0])
            2'd0:    w = {{56{sx & sh[7]}},  sh[7:0]};
            2'd1:    w = {{48{sx & sh[15]}}, sh[15:0]};
            2'd2:    w = {{32{sx & sh[31]}}, sh[31:0]};
            default: w = 64'(sh);
        endcase
        return XLEN'(w);
    endfunction

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [2:0]        f3_q, f3_d;
    logic [OFFW-1:0]   off_q, off_d;
    logic              data_read_q, data_read_d;
    logic [XLEN-1:0]   data_addr_q, data_addr_d;
    logic [NB-1:0]     data_write_q, data_write_d;
    logic [XLEN-1:0]   data_in_q, data_in_d;
    logic              resp_valid_q, resp_valid_d;
    logic [XLEN-1:0]   resp_rdata_q, resp_rdata_d;
    logic              resp_fault_q, resp_fault_d;

    logic [OFFW-1:0]   req_off_s;
    logic              req_fault_s;

    // Request decode: byte offset and fault classification of the incoming request.
    always_comb begin
        req_off_s   = req_addr[OFFW-1:0];
        req_fault_s = f3_illegal(req_funct3, req_we) ||
                      misaligned(req_funct3[1:0], 3'(req_off_s));
    end

    // Next-state and next-output logic; strobes default low so they only pulse in ACCESS.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        f3_d         = f3_q;
        off_d        = off_q;
        data_read_d  = 1'b0;
        data_write_d = '0;
        data_addr_d  = data_addr_q;
        data_in_d    = data_in_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        resp_fault_d = resp_fault_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d  = req_we;
                    f3_d  = req_funct3;
                    off_d = req_off_s;
                    if (req_fault_s) begin
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                        resp_rdata_d = '0;
                        resp_fault_d = 1'b1;
                    end else begin
                        state_d     = S_ACCESS;
                        data_addr_d = {req_addr[XLEN-1:OFFW], {OFFW{1'b0}}};
                        if (req_we) begin
                            data_write_d = lane_mask(req_funct3[1:0], req_off_s);
                            data_in_d    = req_wdata << {req_off_s, 3'b000};
                        end else begin
                            data_read_d = 1'b1;
                        end
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ACCESS: begin
                if (we_q) begin
                    state_d      = S_RESP;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = '0;
                    resp_fault_d = 1'b0;
                end else begin
                    state_d = S_WAIT;
                    cnt_d   = CW'(MEM_LAT - 1);
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d      = S_RESP;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = load_extend(data_out, f3_q, off_q);
                    resp_fault_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset abandons any access in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            we_q         <= 1'b0;
            f3_q         <= 3'b000;
            off_q        <= '0;
            data_read_q  <= 1'b0;
            data_addr_q  <= '0;
            data_write_q <= '0;
            data_in_q    <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_fault_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            f3_q         <= f3_d;
            off_q        <= off_d;
            data_read_q  <= data_read_d;
            data_addr_q  <= data_addr_d;
            data_write_q <= data_write_d;
            data_in_q    <= data_in_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_fault_q <= resp_fault_d;
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_fault = resp_fault_q;
    assign data_read  = data_read_q;
    assign data_addr  = data_addr_q;
    assign data_write = data_write_q;
    assign data_in    = data_in_q;

endmodule

// File: tb/tb_lsu_mem_if.sv
// Bench for lsu_mem_if: a 32-bit/MEM_LAT=1 and a 64-bit/MEM_LAT=3 instance checked
// cycle by cycle against a byte-level behavioural model.
module tb_lsu_mem_if;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        rv_i [2];
    logic        we_i [2];
    logic [2:0]  f3_i [2];
    logic [63:0] addr_i [2];
    logic [63:0] wdata_i [2];
    logic [63:0] dout_i [2];

    logic        rdy32, rv32, flt32, dr32;
    logic [31:0] rdata32, daddr32, din32;
    logic [3:0]  dw32;
    logic        rdy64, rv64, flt64, dr64;
    logic [63:0] rdata64, daddr64, din64;
    logic [7:0]  dw64;

    lsu_mem_if #(.XLEN(32), .MEM_LAT(1)) u32 (
        .clk(clk), .rst(rst),
        .req_valid(rv_i[0]), .req_ready(rdy32), .req_we(we_i[0]), .req_funct3(f3_i[0]),
        .req_addr(addr_i[0][31:0]), .req_wdata(wdata_i[0][31:0]),
        .resp_valid(rv32), .resp_rdata(rdata32), .resp_fault(flt32),
        .data_read(dr32), .data_addr(daddr32), .data_write(dw32), .data_in(din32),
        .data_out(dout_i[0][31:0])
    );

    lsu_mem_if #(.XLEN(64), .MEM_LAT(3)) u64 (
        .clk(clk), .rst(rst),
        .req_valid(rv_i[1]), .req_ready(rdy64), .req_we(we_i[1]), .req_funct3(f3_i[1]),
        .req_addr(addr_i[1]), .req_wdata(wdata_i[1]),
        .resp_valid(rv64), .resp_rdata(rdata64), .resp_fault(flt64),
        .data_read(dr64), .data_addr(daddr64), .data_write(dw64), .data_in(din64),
        .data_out(dout_i[1])
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic        s_rdy, s_rv, s_rf, s_dr;
    logic [7:0]  s_dw;
    logic [63:0] s_addr, s_din, s_rd;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic sample(input int sel);
        if (sel == 0) begin
            s_rdy = rdy32; s_rv = rv32; s_rf = flt32; s_dr = dr32;
            s_dw = 8'(dw32); s_addr = 64'(daddr32); s_din = 64'(din32); s_rd = 64'(rdata32);
        end else begin
            s_rdy = rdy64; s_rv = rv64; s_rf = flt64; s_dr = dr64;
            s_dw = dw64; s_addr = daddr64; s_din = din64; s_rd = rdata64;
        end
    endtask

    // Model: legality and alignment straight from the funct3 table.
    function automatic bit m_fault(input int xlen, input bit we, input logic [2:0] f3, input int off);
        int bytes;
        bit legal;
        bytes = 1 << f3[1:0];
        legal = 1'b1;
        if (f3 == 3'b111) legal = 1'b0;
        if (f3[2] && we) legal = 1'b0;
        if (xlen == 32 && (f3 == 3'b011 || f3 == 3'b110)) legal = 1'b0;
        return !legal || ((off % bytes) != 0);
    endfunction

    function automatic logic [7:0] m_mask(input logic [2:0] f3, input int off);
        logic [7:0] m;
        m = 8'h00;
        for (int i = 0; i < (1 << f3[1:0]); i++) m[off + i] = 1'b1;
        return m;
    endfunction

    // Model: gather the addressed bytes one at a time, then extend.
    function automatic logic [63:0] m_load(input int xlen, input logic [2:0] f3, input int off,
                                           input logic [63:0] dout);
        logic [63:0] v;
        int bytes;
        bytes = 1 << f3[1:0];
        v = 64'h0;
        for (int i = 0; i < bytes; i++) v[8*i +: 8] = dout[8*(off + i) +: 8];
        if (!f3[2] && v[8*bytes - 1])
            for (int i = bytes; i < 8; i++) v[8*i +: 8] = 8'hFF;
        if (xlen == 32) v[63:32] = 32'h0;
        return v;
    endfunction

    // One request on instance sel, checked every cycle until the LSU is idle again.
    task automatic txn(input int sel, input bit we, input logic [2:0] f3, input logic [63:0] addr_in,
                       input logic [63:0] wdata_in, input logic [63:0] dout_in);
        int xlen, ml, nb, off, lat;
        bit flt;
        logic [63:0] xm, addr, wdata, dout, exp_rd;
        logic [7:0] mk;
        xlen  = (sel != 0) ? 64 : 32;
        ml    = (sel != 0) ? 3 : 1;
        nb    = xlen / 8;
        xm    = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        addr  = addr_in & xm;
        wdata = wdata_in & xm;
        dout  = dout_in & xm;
        off   = int'(addr[2:0]) % nb;
        flt   = m_fault(xlen, we, f3, off);
        lat   = flt ? 1 : (we ? 2 : 2 + ml);
        mk    = (flt || !we) ? 8'h00 : m_mask(f3, off);
        exp_rd = (flt || we) ? 64'h0 : m_load(xlen, f3, off, dout);

        sample(sel);
        chk("ready_before_req", 64'(s_rdy), 64'h1);
        rv_i[sel] = 1'b1; we_i[sel] = we; f3_i[sel] = f3;
        addr_i[sel] = addr; wdata_i[sel] = wdata;
        @(posedge clk);
        #1;
        rv_i[sel] = 1'b0; we_i[sel] = 1'($urandom); f3_i[sel] = 3'($urandom);
        addr_i[sel] = {$urandom, $urandom} & xm; wdata_i[sel] = {$urandom, $urandom} & xm;
        for (int c = 1; c <= lat + 1; c++) begin
            @(negedge clk);
            dout_i[sel] = (c == 1 + ml) ? dout : ({$urandom, $urandom} & xm);
            sample(sel);
            chk("req_ready", 64'(s_rdy), 64'(c == lat + 1));
            chk("resp_valid", 64'(s_rv), 64'(c == lat));
            chk("data_read", 64'(s_dr), 64'(!flt && !we && c == 1));
            chk("data_write", 64'(s_dw), (c == 1) ? 64'(mk) : 64'h0);
            if (c == 1 && !flt) begin
                chk("data_addr", s_addr, addr & ~64'(nb - 1));
                if (we)
                    for (int i = 0; i < nb; i++)
                        if (mk[i]) chk("data_in_lane", 64'(s_din[8*i +: 8]), 64'(wdata[8*(i - off) +: 8]));
            end
            if (c == lat) begin
                chk("resp_rdata", s_rd, exp_rd);
                chk("resp_fault", 64'(s_rf), 64'(flt));
            end
        end
    endtask

    task automatic chk_idle(input int sel, input string name);
        sample(sel);
        chk({name, "_ready"}, 64'(s_rdy), 64'h1);
        chk({name, "_rv"}, 64'(s_rv), 64'h0);
        chk({name, "_strobe"}, 64'({s_dr, s_dw}), 64'h0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sel;
        bit we;
        logic [2:0] f3;
        logic [63:0] a;
        rst = 1'b1;
        for (int s = 0; s < 2; s++) begin
            rv_i[s] = 1'b0; we_i[s] = 1'b0; f3_i[s] = 3'b000;
            addr_i[s] = 64'h0; wdata_i[s] = 64'h0; dout_i[s] = 64'h0;
        end
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sample(s);
            chk("reset_ready", 64'(s_rdy), 64'h1);
            chk("reset_outs", 64'({s_rv, s_rf, s_dr, s_dw}), 64'h0);
            chk("reset_addr", s_addr, 64'h0);
            chk("reset_din", s_din, 64'h0);
            chk("reset_rdata", s_rd, 64'h0);
        end
        rst = 1'b0;
        @(negedge clk);

        chk("pin_lb", m_load(32, 3'b000, 3, 64'h8899AABB), 64'hFFFF_FF88);
        chk("pin_lhu", m_load(32, 3'b101, 2, 64'h8899AABB), 64'h0000_8899);
        chk("pin_lh", m_load(32, 3'b001, 0, 64'h8899AABB), 64'hFFFF_AABB);
        chk("pin_ld", m_load(64, 3'b011, 0, 64'h0123456789ABCDEF), 64'h0123456789ABCDEF);
        chk("pin_sb_mask", 64'(m_mask(3'b000, 1)), 64'h2);
        chk("pin_lw_misaligned", 64'(m_fault(32, 1'b0, 3'b010, 2)), 64'h1);
        chk("pin_sbu_illegal", 64'(m_fault(32, 1'b1, 3'b100, 0)), 64'h1);

        txn(0, 1'b0, 3'b000, 64'h103, 64'h0, 64'h8899AABB);
        txn(0, 1'b0, 3'b101, 64'h102, 64'h0, 64'h8899AABB);
        txn(0, 1'b0, 3'b001, 64'h100, 64'h0, 64'h8899AABB);
        txn(0, 1'b1, 3'b000, 64'h201, 64'h0000_00CD, 64'h0);
        txn(0, 1'b0, 3'b010, 64'h102, 64'h0, 64'h8899AABB);
        txn(0, 1'b1, 3'b100, 64'h100, 64'h1234, 64'h0);
        txn(1, 1'b0, 3'b011, 64'h8, 64'h0, 64'h0123456789ABCDEF);
        txn(1, 1'b0, 3'b110, 64'h4, 64'h0, 64'h8000_0001_F000_0000);
        txn(1, 1'b1, 3'b001, 64'h6, 64'hBEEF, 64'h0);

        // Reset while the 32-bit load is in ACCESS: strobe must drop without a clock edge.
        rv_i[0] = 1'b1; we_i[0] = 1'b0; f3_i[0] = 3'b010; addr_i[0] = 64'h100;
        @(posedge clk);
        #1;
        rv_i[0] = 1'b0;
        sample(0);
        chk("rst_pre_read", 64'(s_dr), 64'h1);
        rst = 1'b1;
        #1;
        sample(0);
        chk("rst_async_read", 64'(s_dr), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk_idle(0, "rst_access_after");
        end

        // Reset while the 64-bit load is in WAIT.
        rv_i[1] = 1'b1; we_i[1] = 1'b0; f3_i[1] = 3'b011; addr_i[1] = 64'h8;
        @(posedge clk);
        #1;
        rv_i[1] = 1'b0;
        repeat (2) @(negedge clk);
        sample(1);
        chk("rst_pre_wait_ready", 64'(s_rdy), 64'h0);
        rst = 1'b1;
        #1;
        chk_idle(1, "rst_wait_during");
        @(negedge clk);
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            chk_idle(1, "rst_wait_after");
        end
        txn(1, 1'b0, 3'b010, 64'h10, 64'h0, 64'hCAFEBABE_8765_4321);
        txn(0, 1'b0, 3'b010, 64'h104, 64'h0, 64'h7654_3210);

        for (int k = 0; k < 200; k++) begin
            sel = int'($urandom_range(0, 1));
            we  = 1'($urandom);
            f3  = 3'($urandom);
            a   = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 0) a = a & ~64'h7;
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                chk_idle(sel, "gap");
            end
            txn(sel, we, f3, a, {$urandom, $urandom}, {$urandom, $urandom});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_mem_if.md
Name: lsu_mem_if

Overview:
- Parametrised load/store unit sitting between the CPU execute stage and the data-memory port (data_read / data_addr / data_write / data_in / data_out).
- Successor to the fixed single-cycle data interface: adds a configurable data width, configurable memory read latency, and a request/response handshake.
- Also performs byte/halfword/word(/doubleword) lane steering, load sign/zero extension, and misalignment/illegal-op fault detection.

Parameters:
- XLEN, 32, data/address width; 32 or 64 only.
- MEM_LAT, 1, cycles from the data_read strobe cycle to data_out valid; minimum 1.
- NB, XLEN/8, number of byte lanes (derived; do not override).
- OFFW, log2(NB), width of the byte-offset field (derived).

Ports:
- clk, in, 1, clock, rising edge.
- rst, in, 1, asynchronous active-high reset.
- req_valid, in, 1, CPU access request.
- req_ready, out, 1, LSU can accept; high only in IDLE.
- req_we, in, 1, 1 = store, 0 = load.
- req_funct3, in, 3, RISC-V funct3 size/sign encoding.
- req_addr, in, XLEN, byte address.
- req_wdata, in, XLEN, store data, right-aligned.
- resp_valid, out, 1, one-cycle completion pulse.
- resp_rdata, out, XLEN, extended load result; 0 for stores and faults.
- resp_fault, out, 1, misaligned or illegal access; valid with resp_valid.
- data_read, out, 1, memory read enable.
- data_addr, out, XLEN, memory address with the low OFFW bits forced to 0.
- data_write, out, NB, per-byte write enable.
- data_in, out, XLEN, lane-steered write data.
- data_out, in, XLEN, memory read data.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE; data_read=0; data_write=0; data_addr=0; data_in=0; resp_valid=0; resp_rdata=0; resp_fault=0.
- Reset mid-operation: strobes drop immediately on rst assertion. The access in flight is abandoned and produces no response.
- Registering: all outputs are registered except req_ready, which is decoded from state.
- Acceptance: a request is accepted on a rising edge where req_valid && req_ready. req_* are captured on that edge, and later changes to req_* are ignored.
- Legal funct3 values:
  - 000 = B, 001 = H, 010 = W (all XLEN); 011 = D (XLEN=64 only).
  - 100 = BU, 101 = HU (loads only); 110 = WU (loads only, XLEN=64 only).
  - Any other value, or an unsigned code with req_we=1, is illegal.
- Misalignment: off = req_addr[OFFW-1:0]. Fault if H and off[0]!=0; W and off[1:0]!=0; D and off[2:0]!=0.
- State machine:
  - IDLE: req_ready=1. On accept: faulting request -> RESP, with no memory strobe ever asserted. Otherwise -> ACCESS.
  - ACCESS: exactly one cycle. Drives data_addr.
    - Load: data_read=1, data_write=0.
    - Store: data_read=0, data_write=mask, data_in=steered data.
    - Next state: load -> WAIT; store -> RESP.
  - WAIT: lasts MEM_LAT cycles, tracked by a counter. data_out is captured on the final WAIT edge, then -> RESP.
  - RESP: resp_valid=1 for one cycle, with resp_rdata and resp_fault. Then -> IDLE. There is no response backpressure.
- Strobe deassertion: data_read and data_write are 0 in every state except ACCESS. data_addr and data_in hold their last values.
- Latency, counted from the accepting edge (cycle 0):
  - Load: resp_valid in cycle 2+MEM_LAT.
  - Store: resp_valid in cycle 2.
  - Fault: resp_valid in cycle 1.
- Back-to-back requests: the next request is accepted in the cycle after RESP, once IDLE is re-entered.
- Store lanes:
  - mask = {1, 2'b11, 4'hF, 8'hFF}[size] << off.
  - data_in = req_wdata << (8*off). Bits outside the mask are don't-care but driven deterministically.
- Load extraction:
  - sh = data_out >> (8*off), truncated to the access size.
  - Signed codes sign-extend from the top bit of the size; U codes zero-extend.
  - W on XLEN=32 is passed through unchanged.

Test Plan:
- XLEN=32, MEM_LAT=1, data_out=0x8899AABB, LB at addr 0x103 -> data_read=1 in cycle 1, data_addr=0x100; resp_valid in cycle 3 with resp_rdata=0xFFFFFF88, fault=0.
- Same data, LHU at addr 0x102 -> resp_rdata=0x00008899. Then LH at addr 0x100 -> resp_rdata=0xFFFFAABB.
- SB at addr 0x201 with wdata=0x000000CD -> cycle 1: data_write=4'b0010, data_in[15:8]=0xCD, data_addr=0x200; resp_valid in cycle 2, rdata=0.
- LW at addr 0x102 -> resp_fault=1 in cycle 1; data_read and data_write stay 0 throughout. Separately, funct3=100 with we=1 -> fault.
- MEM_LAT=3, XLEN=64, LD at addr 0x8 with data_out=0x0123456789ABCDEF -> resp_valid in cycle 5, rdata=0x0123456789ABCDEF; req_ready=0 in cycles 1–5.
- Assert rst during WAIT -> data_read=0 asynchronously, no resp_valid, req_ready=1 after release; a new LW then completes normally.
